// File: rtl/alu_writeback_stage_if.sv
// Handshake bundle between the ALU (master) and the EX->WB stage (slave),
// together with the writeback bundle the stage presents to the register file.
interface alu_writeback_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_control;
    logic [DATA_W-1:0]     in_result;
    logic [DATA_W-1:0]     in_result1;
    logic                  in_z;
    logic                  in_c;
    logic                  in_s;
    logic                  in_v;
    logic                  in_flag_we;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_rd_we;
    logic                  in_sel_hi;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     wb_data;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_we;

    modport slave (
        input  in_valid, in_control, in_result, in_result1,
               in_z, in_c, in_s, in_v, in_flag_we, in_rd, in_rd_we, in_sel_hi,
               out_ready,
        output in_ready, out_valid, wb_data, wb_rd, wb_we
    );

    modport master (
        output in_valid, in_control, in_result, in_result1,
               in_z, in_c, in_s, in_v, in_flag_we, in_rd, in_rd_we, in_sel_hi,
               out_ready,
        input  in_ready, out_valid, wb_data, wb_rd, wb_we
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// EX->WB register stage holding HI and the Z/C/S/V flags; 1-cycle latency,
// in_ready drops only while a held bundle is not drained (out_valid & ~out_ready).
module alu_writeback_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_writeback_stage_if.slave  bus,
    input  logic [2:0]            br_sel_i,
    output logic [DATA_W-1:0]     hi_o,
    output logic [3:0]            flags_o,
    output logic                  br_taken_o
);
    localparam logic [3:0] CTRL_MULT  = 4'b0001;
    localparam logic [3:0] CTRL_MULTU = 4'b0010;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_we_q, wb_we_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [3:0]            flags_q, flags_d;
    logic                  in_ready;
    logic                  accept;
    logic                  is_mul;
    logic                  cond;

    assign in_ready = ~out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;
    assign is_mul   = (bus.in_control == CTRL_MULT) || (bus.in_control == CTRL_MULTU);

    always_comb begin
        out_valid_d = out_valid_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = wb_we_q;
        hi_d        = hi_q;
        flags_d     = flags_q;
        if (accept) begin
            out_valid_d = 1'b1;
            // Move-from-HI sees HI before any update carried by the same bundle.
            wb_data_d   = bus.in_sel_hi ? hi_q : bus.in_result;
            wb_rd_d     = bus.in_rd;
            wb_we_d     = bus.in_rd_we & (bus.in_rd != '0);
            if (is_mul) begin
                hi_d = bus.in_result1;
            end
            if (bus.in_flag_we) begin
                flags_d = {bus.in_z, bus.in_c, bus.in_s, bus.in_v};
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_we_q     <= 1'b0;
            hi_q        <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            hi_q        <= hi_d;
            flags_q     <= flags_d;
        end
    end

    // Flag order is {Z,C,S,V}; odd selects invert the chosen flag.
    always_comb begin
        case (br_sel_i[2:1])
            2'd0:    cond = flags_q[3];
            2'd1:    cond = flags_q[2];
            2'd2:    cond = flags_q[1];
            default: cond = flags_q[0];
        endcase
    end

    assign br_taken_o    = br_sel_i[0] ? ~cond : cond;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_we     = wb_we_q & out_valid_q;
    assign hi_o          = hi_q;
    assign flags_o       = flags_q;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed stimulus with a scoreboard queue; a negedge monitor pops one expected
// writeback bundle whenever the stage transfers one to the register file.
module tb_alu_writeback_stage;
    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  flags;
        logic [31:0] hi;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  br_sel;
    logic [31:0] hi;
    logic [3:0]  flags;
    logic        br_taken;

    int checks = 0;
    int errors = 0;
    int n_pop  = 0;
    exp_t exp_q[$];

    alu_writeback_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bif ();

    alu_writeback_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif),
        .br_sel_i   (br_sel),
        .hi_o       (hi),
        .flags_o    (flags),
        .br_taken_o (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (!rst && bif.out_valid === 1'b1 && bif.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got data %0h expected no bundle", bif.wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_pop++;
                chk("wb_data", bif.wb_data, e.data);
                chk("wb_rd",   {27'd0, bif.wb_rd}, {27'd0, e.rd});
                chk("wb_we",   {31'd0, bif.wb_we}, {31'd0, e.we});
                chk("flags",   {28'd0, flags}, {28'd0, e.flags});
                chk("hi",      hi, e.hi);
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] ctrl, input logic [31:0] res, input logic [31:0] res1,
                        input logic [3:0] zcsv, input logic fwe, input logic [4:0] rd,
                        input logic rdwe, input logic selhi, input exp_t e);
        bit got;
        got = 0;
        bif.in_valid   = 1'b1;
        bif.in_control = ctrl;
        bif.in_result  = res;
        bif.in_result1 = res1;
        {bif.in_z, bif.in_c, bif.in_s, bif.in_v} = zcsv;
        bif.in_flag_we = fwe;
        bif.in_rd      = rd;
        bif.in_rd_we   = rdwe;
        bif.in_sel_hi  = selhi;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bif.in_ready === 1'b1) begin
                exp_q.push_back(e);
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 20 cycles expected 1");
            bif.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bif.in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] br_exp;
        br_exp = 8'b1001_1001;
        rst = 1'b0;
        br_sel = 3'd0;
        bif.out_ready = 1'b1;
        bif.in_valid = 1'b0;
        bif.in_control = 4'd0;
        bif.in_result = 32'd0;
        bif.in_result1 = 32'd0;
        {bif.in_z, bif.in_c, bif.in_s, bif.in_v} = 4'd0;
        bif.in_flag_we = 1'b0;
        bif.in_rd = 5'd0;
        bif.in_rd_we = 1'b0;
        bif.in_sel_hi = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
        chk("rst_wb_data", bif.wb_data, 32'd0);
        chk("rst_wb_we", {31'd0, bif.wb_we}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        #9 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
        align();

        // ADD 5+3 -> r4, flags all clear
        send(4'd0, 32'd8, 32'd0, 4'b0000, 1'b1, 5'd4, 1'b1, 1'b0, '{32'd8, 5'd4, 1'b1, 4'b0000, 32'd0});
        // write to r0 suppressed; Z=1 without flag_we leaves flags alone
        send(4'd0, 32'h1234, 32'd0, 4'b1000, 1'b0, 5'd0, 1'b1, 1'b0, '{32'h1234, 5'd0, 1'b0, 4'b0000, 32'd0});
        br_sel = 3'd1;
        @(negedge clk);
        chk("br_notz_after_add", {31'd0, br_taken}, 32'd1);
        align();

        // MULTU 0x10000*0x10000, then MFHI r7 back-to-back
        send(4'b0010, 32'd0, 32'd1, 4'b1000, 1'b1, 5'd0, 1'b0, 1'b0, '{32'd0, 5'd0, 1'b0, 4'b1000, 32'd1});
        send(4'd0, 32'hdead, 32'h99, 4'b0000, 1'b0, 5'd7, 1'b1, 1'b1, '{32'd1, 5'd7, 1'b1, 4'b1000, 32'd1});
        // MULT with sel_hi reads old HI then updates it
        send(4'b0001, 32'h11, 32'h55, 4'b0000, 1'b0, 5'd3, 1'b1, 1'b1, '{32'd1, 5'd3, 1'b1, 4'b1000, 32'h55});
        send(4'd0, 32'h77, 32'd0, 4'b1010, 1'b1, 5'd9, 1'b1, 1'b0, '{32'h77, 5'd9, 1'b1, 4'b1010, 32'h55});
        for (int i = 0; i < 8; i++) begin
            br_sel = 3'(i);
            @(negedge clk);
            chk($sformatf("br_sel_%0d", i), {31'd0, br_taken}, {31'd0, br_exp[i]});
        end
        align();

        // Backpressure: A is held while B waits three cycles
        bif.out_ready = 1'b0;
        send(4'd0, 32'hA0, 32'd0, 4'b0100, 1'b1, 5'd10, 1'b1, 1'b0, '{32'hA0, 5'd10, 1'b1, 4'b0100, 32'h55});
        fork
            send(4'd0, 32'hB0, 32'd0, 4'b0001, 1'b1, 5'd11, 1'b1, 1'b0, '{32'hB0, 5'd11, 1'b1, 4'b0001, 32'h55});
            begin
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, bif.in_ready}, 32'd0);
                    chk("stall_wb_data", bif.wb_data, 32'hA0);
                    chk("stall_flags", {28'd0, flags}, 32'h4);
                end
                @(posedge clk);
                #1 bif.out_ready = 1'b1;
            end
        join
        send(4'd0, 32'hC0, 32'd0, 4'b0010, 1'b1, 5'd12, 1'b1, 1'b0, '{32'hC0, 5'd12, 1'b1, 4'b0010, 32'h55});
        send(4'd0, 32'hD0, 32'd0, 4'b1111, 1'b0, 5'd13, 1'b1, 1'b0, '{32'hD0, 5'd13, 1'b1, 4'b0010, 32'h55});
        repeat (2) @(negedge clk);
        align();

        // Reset while a MULT bundle is stalled in the output register
        bif.out_ready = 1'b0;
        send(4'b0001, 32'hE0, 32'h1EE, 4'b1111, 1'b1, 5'd14, 1'b1, 1'b0, '{32'hE0, 5'd14, 1'b1, 4'b1111, 32'h1EE});
        chk("pre_rst_hi", hi, 32'h1EE);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", {31'd0, bif.out_valid}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_flags", {28'd0, flags}, 32'd0);
        chk("midrst_wb_data", bif.wb_data, 32'd0);
        chk("midrst_wb_we", {31'd0, bif.wb_we}, 32'd0);
        #5 rst = 1'b0;
        bif.out_ready = 1'b1;
        @(negedge clk);
        chk("post_midrst_in_ready", {31'd0, bif.in_ready}, 32'd1);
        chk("post_midrst_out_valid", {31'd0, bif.out_valid}, 32'd0);

        chk("bundles_drained", n_pop, 32'd10);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
